// File: rtl/tortoise_pkg.sv
// Shared types for the tortoise core's commit path: scoreboard entry layout,
// commit controller states and the default flush length.
package tortoise_pkg;

    localparam int unsigned FLUSH_CYCLES_DEFAULT = 2;

    typedef enum logic [1:0] {
        RUN,
        TRAP,
        FLUSH,
        HALT
    } commit_state_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  cause;
        logic [31:0] tval;
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [7:0]  op;
        logic [4:0]  rd;
        logic [31:0] result;
        exception_t  ex;
    } scoreboard_entry_t;

endpackage

// File: rtl/commit_ctrl.sv
// Commit controller: one registered slot between scoreboard head and commit
// stage, plus the redirect/halt FSM and the retired-instruction counter.
module commit_ctrl
    import tortoise_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sb_valid_i,
    input  scoreboard_entry_t sb_instr_i,
    output logic              sb_ack_o,
    output logic              commit_valid_o,
    output scoreboard_entry_t commit_instr_o,
    input  logic              commit_ack_i,
    input  logic              mispredict_i,
    input  logic              csr_done_i,
    input  logic              flush_i,
    input  logic              halt_i,
    output logic              halted_o,
    output logic              flush_o,
    output logic [63:0]       instret_o
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    commit_state_t     state_q, state_d;
    logic              slot_valid_q, slot_valid_d;
    scoreboard_entry_t slot_q, slot_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              flush_q, halted_q;
    logic [63:0]       instret_q;
    logic              ack_valid, retire, load;

    // An acknowledge only means something when the slot actually holds an entry.
    assign ack_valid = slot_valid_q && commit_ack_i;
    assign retire    = ack_valid && !slot_q.ex.valid;

    always_comb begin
        state_d      = state_q;
        slot_valid_d = slot_valid_q;
        slot_d       = slot_q;
        cnt_d        = cnt_q;
        load         = 1'b0;
        if (flush_i && state_q != HALT) begin
            state_d      = FLUSH;
            cnt_d        = FLUSH_INIT;
            slot_valid_d = 1'b0;
            slot_d       = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (ack_valid && slot_q.ex.valid) begin
                        state_d      = TRAP;
                        slot_valid_d = 1'b0;
                        slot_d       = '0;
                    end else if (ack_valid && mispredict_i) begin
                        state_d      = FLUSH;
                        cnt_d        = FLUSH_INIT;
                        slot_valid_d = 1'b0;
                        slot_d       = '0;
                    end else if (halt_i && (!slot_valid_q || ack_valid)) begin
                        state_d      = HALT;
                        slot_valid_d = 1'b0;
                        slot_d       = '0;
                    end else begin
                        load = sb_valid_i && (!slot_valid_q || ack_valid);
                        if (load) begin
                            slot_valid_d = 1'b1;
                            slot_d       = sb_instr_i;
                        end else if (ack_valid) begin
                            slot_valid_d = 1'b0;
                        end
                    end
                end
                TRAP: begin
                    if (csr_done_i) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end
                end
                FLUSH: begin
                    // Leaving on a count of one keeps flush_o high for exactly FLUSH_CYCLES.
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                HALT: begin
                    if (!halt_i) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            slot_valid_q <= 1'b0;
            slot_q       <= '0;
            cnt_q        <= 3'd0;
            flush_q      <= 1'b0;
            halted_q     <= 1'b0;
            instret_q    <= 64'd0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_q       <= slot_d;
            cnt_q        <= cnt_d;
            flush_q      <= (state_d == FLUSH);
            halted_q     <= (state_d == HALT);
            instret_q    <= instret_q + 64'(retire);
        end
    end

    assign sb_ack_o       = load && !rst_i;
    assign commit_valid_o = slot_valid_q;
    assign commit_instr_o = slot_q;
    assign flush_o        = flush_q;
    assign halted_o       = halted_q;
    assign instret_o      = instret_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed bench for commit_ctrl: a per-cycle vector table with hand-computed
// outputs, followed by a reset-during-flush sequence.
module tb_commit_ctrl;
    import tortoise_pkg::*;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct {
        logic        sbv;
        logic [31:0] pc;
        logic        exv;
        logic        ack;
        logic        mp;
        logic        csr;
        logic        fl;
        logic        hlt;
        logic        e_sback;
        logic        e_cv;
        logic [31:0] e_pc;
        logic        e_flush;
        logic        e_halted;
        logic [63:0] e_ir;
    } vec_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              sb_valid_i;
    scoreboard_entry_t sb_instr_i;
    logic              sb_ack_o;
    logic              commit_valid_o;
    scoreboard_entry_t commit_instr_o;
    logic              commit_ack_i;
    logic              mispredict_i;
    logic              csr_done_i;
    logic              flush_i;
    logic              halt_i;
    logic              halted_o;
    logic              flush_o;
    logic [63:0]       instret_o;

    int n_vectors = 0;
    int n_miscompares = 0;
    vec_t vecs[$];

    commit_ctrl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sb_valid_i     (sb_valid_i),
        .sb_instr_i     (sb_instr_i),
        .sb_ack_o       (sb_ack_o),
        .commit_valid_o (commit_valid_o),
        .commit_instr_o (commit_instr_o),
        .commit_ack_i   (commit_ack_i),
        .mispredict_i   (mispredict_i),
        .csr_done_i     (csr_done_i),
        .flush_i        (flush_i),
        .halt_i         (halt_i),
        .halted_o       (halted_o),
        .flush_o        (flush_o),
        .instret_o      (instret_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic sbv, input logic [31:0] pc, input logic exv,
                                input logic ack, input logic mp, input logic csr,
                                input logic fl, input logic hlt, input logic e_sback,
                                input logic e_cv, input logic [31:0] e_pc, input logic e_flush,
                                input logic e_halted, input logic [63:0] e_ir);
        vec_t v;
        v.sbv = sbv; v.pc = pc; v.exv = exv; v.ack = ack; v.mp = mp; v.csr = csr;
        v.fl = fl; v.hlt = hlt; v.e_sback = e_sback; v.e_cv = e_cv; v.e_pc = e_pc;
        v.e_flush = e_flush; v.e_halted = e_halted; v.e_ir = e_ir;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        sb_valid_i        = v.sbv;
        sb_instr_i        = '0;
        sb_instr_i.pc     = v.pc;
        sb_instr_i.op     = v.pc[7:0] ^ 8'h5a;
        sb_instr_i.result = v.pc ^ 32'hA5A5_0000;
        sb_instr_i.ex.valid = v.exv;
        commit_ack_i      = v.ack;
        mispredict_i      = v.mp;
        csr_done_i        = v.csr;
        flush_i           = v.fl;
        halt_i            = v.hlt;
    endtask

    task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkField({tag, " sb_ack"}, 64'(sb_ack_o), 64'(v.e_sback));
        checkField({tag, " commit_valid"}, 64'(commit_valid_o), 64'(v.e_cv));
        checkField({tag, " flush"}, 64'(flush_o), 64'(v.e_flush));
        checkField({tag, " halted"}, 64'(halted_o), 64'(v.e_halted));
        checkField({tag, " instret"}, instret_o, v.e_ir);
        if (v.e_cv) begin
            checkField({tag, " commit_pc"}, 64'(commit_instr_o.pc), 64'(v.e_pc));
            checkField({tag, " commit_result"}, 64'(commit_instr_o.result),
                       64'(v.e_pc ^ 32'hA5A5_0000));
        end
    endtask

    initial begin
        vec_t v;
        // Four back-to-back ALU entries with the commit stage always acking.
        vecs.push_back(mk(H,32'h10,L,H,L,L,L,L, H,L,32'h0, L,L,64'd0));
        vecs.push_back(mk(H,32'h11,L,H,L,L,L,L, H,H,32'h10,L,L,64'd0));
        vecs.push_back(mk(H,32'h12,L,H,L,L,L,L, H,H,32'h11,L,L,64'd1));
        vecs.push_back(mk(H,32'h13,L,H,L,L,L,L, H,H,32'h12,L,L,64'd2));
        vecs.push_back(mk(L,32'h0, L,H,L,L,L,L, L,H,32'h13,L,L,64'd3));
        vecs.push_back(mk(L,32'h0, L,L,L,L,L,L, L,L,32'h0, L,L,64'd4));
        // Mispredict at ack: two flush cycles, retirement still counted.
        vecs.push_back(mk(H,32'h20,L,L,L,L,L,L, H,L,32'h0, L,L,64'd4));
        vecs.push_back(mk(H,32'h21,L,H,H,L,L,L, L,H,32'h20,L,L,64'd4));
        vecs.push_back(mk(H,32'h21,L,L,L,L,L,L, L,L,32'h0, H,L,64'd5));
        vecs.push_back(mk(H,32'h21,L,L,L,L,L,L, L,L,32'h0, H,L,64'd5));
        vecs.push_back(mk(H,32'h21,L,L,L,L,L,L, H,L,32'h0, L,L,64'd5));
        vecs.push_back(mk(L,32'h0, L,H,L,L,L,L, L,H,32'h21,L,L,64'd5));
        // Exception entry: five TRAP cycles, then flush, no count.
        vecs.push_back(mk(H,32'h30,H,L,L,L,L,L, H,L,32'h0, L,L,64'd6));
        vecs.push_back(mk(L,32'h0, L,H,L,L,L,L, L,H,32'h30,L,L,64'd6));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(H,32'h31,L,H,L,L,L,L, L,L,32'h0, L,L,64'd6));
        vecs.push_back(mk(H,32'h31,L,L,L,H,L,L, L,L,32'h0, L,L,64'd6));
        vecs.push_back(mk(H,32'h31,L,L,L,L,L,L, L,L,32'h0, H,L,64'd6));
        vecs.push_back(mk(H,32'h31,L,L,L,L,L,L, L,L,32'h0, H,L,64'd6));
        vecs.push_back(mk(H,32'h31,L,L,L,L,L,L, H,L,32'h0, L,L,64'd6));
        vecs.push_back(mk(L,32'h0, L,H,L,L,L,L, L,H,32'h31,L,L,64'd6));
        // flush_i beats an exception ack in the same cycle.
        vecs.push_back(mk(H,32'h40,H,L,L,L,L,L, H,L,32'h0, L,L,64'd7));
        vecs.push_back(mk(L,32'h0, L,H,L,L,H,L, L,H,32'h40,L,L,64'd7));
        vecs.push_back(mk(L,32'h0, L,L,L,L,L,L, L,L,32'h0, H,L,64'd7));
        vecs.push_back(mk(L,32'h0, L,L,L,L,L,L, L,L,32'h0, H,L,64'd7));
        vecs.push_back(mk(L,32'h0, L,L,L,L,L,L, L,L,32'h0, L,L,64'd7));
        // flush_i with a normal retirement: the retirement counts; halt waits out FLUSH.
        vecs.push_back(mk(H,32'h50,L,L,L,L,L,L, H,L,32'h0, L,L,64'd7));
        vecs.push_back(mk(H,32'h51,L,H,L,L,H,L, L,H,32'h50,L,L,64'd7));
        vecs.push_back(mk(H,32'h51,L,L,L,L,L,H, L,L,32'h0, H,L,64'd8));
        vecs.push_back(mk(H,32'h51,L,L,L,L,L,H, L,L,32'h0, H,L,64'd8));
        vecs.push_back(mk(L,32'h0, L,L,L,L,L,L, L,L,32'h0, L,L,64'd8));
        // Halt with a full slot, acked one cycle later.
        vecs.push_back(mk(H,32'h60,L,L,L,L,L,L, H,L,32'h0, L,L,64'd8));
        vecs.push_back(mk(H,32'h61,L,L,L,L,L,H, L,H,32'h60,L,L,64'd8));
        vecs.push_back(mk(H,32'h61,L,H,L,L,L,H, L,H,32'h60,L,L,64'd8));
        vecs.push_back(mk(H,32'h61,L,L,L,L,L,H, L,L,32'h0, L,H,64'd9));
        vecs.push_back(mk(H,32'h61,L,L,L,L,L,H, L,L,32'h0, L,H,64'd9));
        vecs.push_back(mk(H,32'h61,L,L,L,L,L,L, L,L,32'h0, L,H,64'd9));
        vecs.push_back(mk(H,32'h61,L,L,L,L,L,L, H,L,32'h0, L,L,64'd9));
        vecs.push_back(mk(L,32'h0, L,H,L,L,L,L, L,H,32'h61,L,L,64'd9));
        // Ack/mispredict with an empty slot is ignored.
        vecs.push_back(mk(L,32'h0, L,H,H,L,L,L, L,L,32'h0, L,L,64'd10));
        vecs.push_back(mk(L,32'h0, L,L,L,L,L,L, L,L,32'h0, L,L,64'd10));

        rst_i = 1'b1;
        applyStimulus(mk(H,32'h99,L,L,L,L,L,L, L,L,32'h0,L,L,64'd0));
        @(negedge clk_i);
        #1;
        checkOutput("reset", mk(H,32'h0,L,L,L,L,L,L, L,L,32'h0,L,L,64'd0));
        checkField("reset commit_instr", 64'(commit_instr_o.pc) | 64'(commit_instr_o.result),
                   64'd0);
        @(negedge clk_i);
        applyStimulus(mk(L,32'h0,L,L,L,L,L,L, L,L,32'h0,L,L,64'd0));
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted while the flush counter sits at one.
        @(negedge clk_i);
        v = mk(H,32'h70,L,L,L,L,L,L, H,L,32'h0,L,L,64'd10);
        applyStimulus(v); #1; checkOutput("rstflush load", v);
        @(negedge clk_i);
        v = mk(L,32'h0,L,H,H,L,L,L, L,H,32'h70,L,L,64'd10);
        applyStimulus(v); #1; checkOutput("rstflush mispredict", v);
        @(negedge clk_i);
        v = mk(H,32'h71,L,L,L,L,L,L, L,L,32'h0,H,L,64'd11);
        applyStimulus(v); #1; checkOutput("rstflush cnt2", v);
        @(negedge clk_i);
        #1; checkOutput("rstflush cnt1", v);
        #1 rst_i = 1'b1;
        #1; checkOutput("rstflush in reset", mk(H,32'h71,L,L,L,L,L,L, L,L,32'h0,L,L,64'd0));
        @(negedge clk_i);
        rst_i = 1'b0;
        #1; checkOutput("rstflush released", mk(H,32'h71,L,L,L,L,L,L, H,L,32'h0,L,L,64'd0));
        @(negedge clk_i);
        v = mk(L,32'h0,L,L,L,L,L,L, L,H,32'h71,L,L,64'd0);
        applyStimulus(v); #1; checkOutput("rstflush run", v);
        @(negedge clk_i);
        #1; checkOutput("rstflush quiet", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/commit_ctrl.md
COMMIT_CTRL -- requirements
Module: commit_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush_o stays high per recovery (legal 1..7).
REQ-002 SHALL have ports: clk_i  in  1  clock (rising edge); rst_i  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports: sb_valid_i  in  1  scoreboard head entry completed; sb_instr_i  in  tortoise_pkg::scoreboard_entry_t  head entry; sb_ack_o  out  1  pop head this cycle.
REQ-004 SHALL have ports: commit_valid_o  out  1  slot holds entry for commit stage; commit_instr_o  out  scoreboard_entry_t  slot contents; commit_ack_i  in  1  commit stage retired slot entry.
REQ-005 SHALL have ports: mispredict_i  in  1  commit stage branch mispredict (qualified by commit_ack_i); csr_done_i  in  1  CSR unit finished trap entry; flush_i  in  1  external flush request (fence, CSR write).
REQ-006 SHALL have ports: halt_i  in  1  debug halt request; halted_o  out  1  core quiescent in debug; flush_o  out  1  flush frontend/issue; instret_o  out  64  retired-instruction count.

Function
REQ-007 SHALL hold one registered commit slot between scoreboard head and commit stage; commit_instr_o/commit_valid_o driven from slot flops only.
REQ-008 SHALL implement FSM states RUN, TRAP, FLUSH, HALT.
REQ-009 RUN: sb_ack_o = sb_valid_i && (!commit_valid_o || (commit_ack_i && no redirect event this cycle)); on sb_ack_o, slot loads sb_instr_i next cycle (1-cycle latency, back-to-back throughput 1/cycle).
REQ-010 RUN: commit_ack_i with no load SHALL clear commit_valid_o next cycle.
REQ-011 RUN: commit_ack_i && mispredict_i && !ex.valid SHALL clear slot, set flush counter to FLUSH_CYCLES, enter FLUSH; sb_ack_o=0 that cycle.
REQ-012 RUN: commit_ack_i && commit_instr_o.ex.valid SHALL clear slot, enter TRAP; sb_ack_o=0 that cycle.
REQ-013 TRAP: sb_ack_o=0, commit_valid_o=0; csr_done_i SHALL move to FLUSH with counter=FLUSH_CYCLES.
REQ-014 FLUSH: flush_o=1, sb_ack_o=0, counter decrements each cycle; at counter==1 next state RUN (flush_o high exactly FLUSH_CYCLES cycles).
REQ-015 flush_i in any state except HALT SHALL clear slot and restart FLUSH with counter=FLUSH_CYCLES; retirement acknowledged in same cycle still counts.
REQ-016 halt_i in RUN with slot empty (or emptied by commit_ack_i this cycle) and no redirect event SHALL enter HALT, sb_ack_o=0 that cycle; halt_i in TRAP/FLUSH deferred until RUN.
REQ-017 HALT: halted_o=1, sb_ack_o=0; halt_i low SHALL return to RUN next cycle.
REQ-018 Priority in same cycle: flush_i > exception > mispredict > halt_i > new load.
REQ-019 instret_o SHALL increment by 1 on commit_valid_o && commit_ack_i && !commit_instr_o.ex.valid; wraps modulo 2^64.
REQ-020 commit_ack_i while commit_valid_o=0 SHALL be ignored (no count, no state change).
REQ-021 flush_o, halted_o SHALL be registered (state-decoded), not combinational from inputs.

Reset
REQ-022 rst_i high SHALL asynchronously force state RUN, commit_valid_o=0, commit_instr_o='0, flush_o=0, halted_o=0, instret_o=0, flush counter=0.
REQ-023 sb_ack_o SHALL be 0 while rst_i high; reset mid-TRAP/FLUSH abandons recovery with no residual flush_o.

Structure
REQ-024 FSM state enum commit_state_t and FLUSH_CYCLES default constant SHALL live in tortoise_pkg; scoreboard_entry_t reused from tortoise_pkg.
REQ-025 Single module; no sub-module except 64-bit counter inline.

Verification
REQ-026 Stream 4 completed ALU entries, commit_ack_i always 1 -> sb_ack_o high 4 consecutive cycles, commit_valid_o high cycles 2..5, instret_o=4.
REQ-027 Entry with mispredict_i=1 at ack, FLUSH_CYCLES=2 -> flush_o high exactly 2 cycles, sb_ack_o=0 during them, instret_o+1, RUN resumes cycle 3.
REQ-028 Entry with ex.valid=1 acked, csr_done_i 5 cycles later -> TRAP 5 cycles, then flush_o 2 cycles, instret_o unchanged.
REQ-029 flush_i and exception ack same cycle -> FLUSH entered (not TRAP), flush_o 2 cycles.
REQ-030 halt_i with slot full, commit_ack_i next cycle -> HALT entered, halted_o=1 following cycle, sb_ack_o=0 until halt_i drops; then RUN.
REQ-031 rst_i asserted during FLUSH counter=1 -> flush_o=0, commit_valid_o=0, instret_o=0 immediately, RUN after release.
